// File: rtl/fwd_mux_stage.sv
// ---------------------------------------------------------------------------
// fwd_mux_stage
//
// One-stage registered forwarding mux. Each cycle, one of NSRC packed
// sources is picked by select_i and registered onto data_o/valid_o. A select
// that names a source which does not exist is still accepted: it produces a
// live all-zero operand and is recorded in a sticky flag and a saturating
// counter.
//
// Handshake: there is no ready. An operand is taken when it is offered with
// valid_i=1 and the stage is neither stalled nor flushed
// (valid_i & ~stall_i & ~flush_i). An operand offered while stall_i or
// flush_i is high is dropped; the upstream side must hold or replay it.
// valid_o=1 marks data_o as a live operand. After a bubble (valid_i=0),
// data_o keeps its last value but valid_o is 0.
//
// Priority at each edge: rst_i > flush_i > stall_i > normal update.
// clr_err_i acts on the error state whether or not the stage is stalled or
// flushed. An illegal event in the same cycle as clr_err_i wins, so the error
// state restarts at flag=1 and count=1.
//
// All outputs come straight from registers. No input reaches an output
// through combinational logic alone.
//
// Ports
//   clk_i          clock; all state updates on the rising edge
//   rst_i          synchronous, active-high reset
//   data_i         NSRC*WIDTH packed sources; source k is [k*WIDTH +: WIDTH]
//   select_i       binary source index, sampled together with valid_i
//   valid_i        an operand is offered this cycle
//   stall_i        hold the output stage
//   flush_i        clear the output stage contents
//   clr_err_i      clear illegal_o and illegal_cnt_o
//   data_o         registered selected operand
//   valid_o        data_o carries a live operand
//   illegal_o      sticky: an illegal select was accepted since the last clear
//   illegal_cnt_o  saturating count of accepted illegal selects
// ---------------------------------------------------------------------------
module fwd_mux_stage #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 3,
    parameter int SELW  = 2,
    parameter int CNTW  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NSRC*WIDTH-1:0] data_i,
    input  logic [SELW-1:0]       select_i,
    input  logic                  valid_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  clr_err_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o,
    output logic                  illegal_o,
    output logic [CNTW-1:0]       illegal_cnt_o
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_illegal;
    logic [CNTW-1:0]  r_cnt;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_illegal;
    logic             w_accept;
    logic             w_illegal_evt;
    logic             w_cnt_sat;

    // Parametric mux. Each source is compared against select_i in a loop.
    // An index with no matching source leaves the default of all-zeros,
    // which is the value an illegal select must load.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (select_i == SELW'(k)) begin
                w_sel_data = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    // Compare with one extra bit so that NSRC == 2**SELW does not overflow.
    assign w_sel_illegal = ({1'b0, select_i} >= (SELW+1)'(NSRC));
    assign w_accept      = valid_i & ~stall_i & ~flush_i;
    assign w_illegal_evt = w_accept & w_sel_illegal;
    assign w_cnt_sat     = (r_cnt == {CNTW{1'b1}});

    // Operand stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (flush_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (stall_i) begin
            r_data  <= r_data;
            r_valid <= r_valid;
        end else if (valid_i) begin
            r_data  <= w_sel_data;
            r_valid <= 1'b1;
        end else begin
            // Bubble: keep the stale data but mark it not live.
            r_valid <= 1'b0;
        end
    end

    // Error tracking. This block does not look at stall or flush directly.
    // Those signals only matter through w_accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (w_illegal_evt) begin
            r_illegal <= 1'b1;
            if (clr_err_i) begin
                r_cnt <= CNTW'(1);
            end else if (!w_cnt_sat) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
        end else if (clr_err_i) begin
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end
    end

    assign data_o        = r_data;
    assign valid_o       = r_valid;
    assign illegal_o     = r_illegal;
    assign illegal_cnt_o = r_cnt;

endmodule

// File: tb/tb_fwd_mux_stage.sv
module tb_fwd_mux_stage;

    localparam int WIDTH = 32;
    localparam int NSRC  = 3;
    localparam int SELW  = 2;
    localparam int CNTW  = 8;

    localparam logic [WIDTH-1:0] S0 = 32'h1111_1111;
    localparam logic [WIDTH-1:0] S1 = 32'h2222_2222;
    localparam logic [WIDTH-1:0] S2 = 32'h3333_3333;

    // ---------------- clock / reset / DUT ----------------
    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NSRC*WIDTH-1:0] data_i;
    logic [SELW-1:0]       select_i;
    logic                  valid_i;
    logic                  stall_i;
    logic                  flush_i;
    logic                  clr_err_i;
    logic [WIDTH-1:0]      data_o;
    logic                  valid_o;
    logic                  illegal_o;
    logic [CNTW-1:0]       illegal_cnt_o;

    always #5 clk_i = ~clk_i;

    fwd_mux_stage #(
        .WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .CNTW(CNTW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .select_i     (select_i),
        .valid_i      (valid_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .clr_err_i    (clr_err_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .illegal_o    (illegal_o),
        .illegal_cnt_o(illegal_cnt_o)
    );

    // ---------------- vector table ----------------
    typedef struct {
        string            name;
        logic [SELW-1:0]  sel;
        logic             v, st, fl, clr, rst;
        logic [WIDTH-1:0] e_data;
        logic             e_valid, e_ill;
        logic [CNTW-1:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input string name, input int sel, input bit v, st, fl, clr, rst,
                       input logic [WIDTH-1:0] ed, input bit ev, ei, input int ec);
        vec_t t;
        t.name = name; t.sel = SELW'(sel); t.v = v; t.st = st; t.fl = fl;
        t.clr = clr; t.rst = rst; t.e_data = ed; t.e_valid = ev; t.e_ill = ei;
        t.e_cnt = CNTW'(ec);
        vecs.push_back(t);
    endtask

    // ---------------- driver / checker tasks ----------------
    // Inputs are set just after an edge. After the next edge, a 1-unit delay
    // gives the registers time to update before the outputs are sampled.
    task automatic drive(input int sel, input bit v, st, fl, clr, rst);
        select_i = SELW'(sel); valid_i = v; stall_i = st; flush_i = fl;
        clr_err_i = clr; rst_i = rst;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] ed,
                         input bit ev, ei, input logic [CNTW-1:0] ec);
        n_checks++;
        if (data_o !== ed || valid_o !== ev || illegal_o !== ei || illegal_cnt_o !== ec) begin
            n_fail++;
            $display("FAIL %s: got data=%h valid=%b ill=%b cnt=%0d, expected data=%h valid=%b ill=%b cnt=%0d",
                     name, data_o, valid_o, illegal_o, illegal_cnt_o, ed, ev, ei, ec);
        end
    endtask

    task automatic set_srcs(input logic [WIDTH-1:0] a, b, c);
        data_i = {c, b, a};
    endtask

    initial begin
        set_srcs(S0, S1, S2);
        select_i = '0; valid_i = 0; stall_i = 0; flush_i = 0; clr_err_i = 0; rst_i = 1;
        #1;

        //   name            sel v  st fl clr rst  data  valid ill cnt
        add("reset",          0, 1, 0, 0, 0, 1,   '0,   0, 0, 0);
        add("sel0",           0, 1, 0, 0, 0, 0,   S0,   1, 0, 0);
        add("sel1",           1, 1, 0, 0, 0, 0,   S1,   1, 0, 0);
        add("sel2",           2, 1, 0, 0, 0, 0,   S2,   1, 0, 0);
        add("bubble_hold",    0, 0, 0, 0, 0, 0,   S2,   0, 0, 0);
        add("bubble_hold2",   1, 0, 0, 0, 0, 0,   S2,   0, 0, 0);
        add("illegal1",       3, 1, 0, 0, 0, 0,   '0,   1, 1, 1);
        add("sel1_after_ill", 1, 1, 0, 0, 0, 0,   S1,   1, 1, 1);
        add("stall_legal",    0, 1, 1, 0, 0, 0,   S1,   1, 1, 1);
        add("stall_illegal",  3, 1, 1, 0, 0, 0,   S1,   1, 1, 1);
        add("stall_flush",    3, 1, 1, 1, 0, 0,   '0,   0, 1, 1);
        add("flush_valid",    0, 1, 0, 1, 0, 0,   '0,   0, 1, 1);
        add("illegal2",       3, 1, 0, 0, 0, 0,   '0,   1, 1, 2);
        add("illegal3",       3, 1, 0, 0, 0, 0,   '0,   1, 1, 3);
        add("illegal4",       3, 1, 0, 0, 0, 0,   '0,   1, 1, 4);
        add("illegal5",       3, 1, 0, 0, 0, 0,   '0,   1, 1, 5);
        add("clr_with_ill",   3, 1, 0, 0, 1, 0,   '0,   1, 1, 1);
        add("clr_alone",      0, 0, 0, 0, 1, 0,   '0,   0, 0, 0);
        add("sel2_reload",    2, 1, 0, 0, 0, 0,   S2,   1, 0, 0);
        add("illegal_again",  3, 1, 0, 0, 0, 0,   '0,   1, 1, 1);
        add("clr_in_stall",   3, 1, 1, 0, 1, 0,   '0,   1, 0, 0);
        add("clr_in_flush",   3, 1, 0, 1, 1, 0,   '0,   0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].v, vecs[i].st, vecs[i].fl, vecs[i].clr, vecs[i].rst);
            check(vecs[i].name, vecs[i].e_data, vecs[i].e_valid, vecs[i].e_ill, vecs[i].e_cnt);
        end

        // ---- stall holds while select and sources change ----
        drive(1, 1, 0, 0, 0, 0);
        check("stall_load", S1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            set_srcs(WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
            drive(i, 1, 1, 0, 0, 0);
            check("stall_hold", S1, 1, 0, 0);
        end
        drive(2, 1, 1, 1, 0, 0);
        check("stall_and_flush", '0, 0, 0, 0);
        set_srcs(S0, S1, S2);

        // ---- counter saturation: 1 illegal accept, then 300 more ----
        begin
            int exp_cnt;
            exp_cnt = 0;
            for (int i = 0; i < 301; i++) begin
                drive(3, 1, 0, 0, 0, 0);
                if (exp_cnt < 255) exp_cnt++;
                check("saturate", '0, 1, 1, CNTW'(exp_cnt));
            end
        end
        // reset while saturated, then the first accept behaves as from power-up
        drive(0, 1, 0, 0, 0, 1);
        check("reset_saturated", '0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        check("post_sat_reset_sel0", S0, 1, 0, 0);

        // ---- reset during stall with cnt=7, valid_o=1 ----
        for (int i = 0; i < 7; i++) drive(3, 1, 0, 0, 0, 0);
        drive(2, 1, 0, 0, 0, 0);
        check("pre_stall_cnt7", S2, 1, 1, 7);
        drive(0, 1, 1, 0, 0, 0);
        check("stall_cnt7", S2, 1, 1, 7);
        drive(0, 1, 1, 0, 0, 1);
        check("reset_in_stall", '0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        check("after_reset_sel1", S1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
